dm_port_arbiter: RTL and testbench

DM_PORT_ARBITER -- requirements
Module: dm_port_arbiter

---
 rtl/dm_port_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_dm_port_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter
// Shares one single-port data memory between the pipeline M stage and a
// bridge/debug port. The M stage normally wins; the bridge is guaranteed
// progress by a starvation counter that flips priority after STARVE_LIMIT
// consecutive lost arbitrations. Memory reads return one cycle after grant.

module dm_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        M_Req,
    input  logic        M_WE,
    input  logic [31:0] M_Addr,
    input  logic [31:0] M_WD,
    input  logic [3:0]  M_BE,
    output logic        M_Stall,
    output logic [31:0] M_RD,
    input  logic        X_Req,
    input  logic        X_WE,
    input  logic [31:0] X_Addr,
    input  logic [31:0] X_WD,
    input  logic [3:0]  X_BE,
    output logic        X_Ack,
    output logic [31:0] X_RD,
    output logic        Mem_En,
    output logic        Mem_WE,
    output logic [11:0] Mem_Addr,
    output logic [31:0] Mem_WD,
    output logic [3:0]  Mem_BE,
    input  logic [31:0] Mem_RD
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_X_RESP = 1'b1
    } state_t;

    localparam logic [2:0] STARVE_LIM = 3'(STARVE_LIMIT);
    localparam logic [2:0] STARVE_MAX = 3'd7;

    state_t      state_q, state_d;
    logic [2:0]  starve_cnt_q, starve_cnt_d;
    logic        m_rd_pending_q, m_rd_pending_d;
    logic [31:0] m_rd_q, m_rd_d;
    logic [31:0] x_rd_q, x_rd_d;

    logic        x_elig_s;
    logic        starved_s;
    logic        grant_x_s;
    logic        grant_m_s;
    logic        x_ack_s;
    logic [31:0] m_rd_s;
    logic [31:0] x_rd_s;

    // Address bits outside the 4K-word window and the byte offset are ignored.
    logic unused_addr_bits_s;
    assign unused_addr_bits_s = ^{M_Addr[31:14], M_Addr[1:0], X_Addr[31:14], X_Addr[1:0]};

    // Arbitration: bridge only when idle; it beats M only once starved or when M is quiet.
    always_comb begin
        x_elig_s  = (state_q == ST_IDLE) && X_Req;
        starved_s = (starve_cnt_q >= STARVE_LIM);
        grant_x_s = 1'b0;
        grant_m_s = 1'b0;
        if (Reset) begin
            grant_x_s = 1'b0;
            grant_m_s = 1'b0;
        end else if (x_elig_s && (!M_Req || starved_s)) begin
            grant_x_s = 1'b1;
        end else if (M_Req) begin
            grant_m_s = 1'b1;
        end else begin
            grant_x_s = 1'b0;
            grant_m_s = 1'b0;
        end
    end

    // Memory port mux: granted requester's fields, all-zero when nobody is granted.
    always_comb begin
        Mem_En   = 1'b0;
        Mem_WE   = 1'b0;
        Mem_Addr = 12'd0;
        Mem_WD   = 32'd0;
        Mem_BE   = 4'd0;
        if (grant_x_s) begin
            Mem_En   = 1'b1;
            Mem_WE   = X_WE;
            Mem_Addr = X_Addr[13:2];
            Mem_WD   = X_WD;
            Mem_BE   = X_BE;
        end else if (grant_m_s) begin
            Mem_En   = 1'b1;
            Mem_WE   = M_WE;
            Mem_Addr = M_Addr[13:2];
            Mem_WD   = M_WD;
            Mem_BE   = M_BE;
        end else begin
            Mem_En   = 1'b0;
        end
    end

    // Response side: bridge ack/data in X_RESP, M read data one cycle after a load grant.
    always_comb begin
        x_ack_s = 1'b0;
        m_rd_s  = m_rd_q;
        x_rd_s  = x_rd_q;
        if (Reset) begin
            x_ack_s = 1'b0;
            m_rd_s  = 32'd0;
            x_rd_s  = 32'd0;
        end else begin
            x_ack_s = (state_q == ST_X_RESP);
            if (m_rd_pending_q) begin
                m_rd_s = Mem_RD;
            end else begin
                m_rd_s = m_rd_q;
            end
            if (x_ack_s) begin
                x_rd_s = Mem_RD;
            end else begin
                x_rd_s = x_rd_q;
            end
        end
    end

    // Next-state: bridge FSM, starvation counter, pending-read flag and held read data.
    always_comb begin
        state_d        = state_q;
        starve_cnt_d   = starve_cnt_q;
        m_rd_pending_d = grant_m_s && !M_WE;
        m_rd_d         = m_rd_s;
        x_rd_d         = x_rd_s;

        case (state_q)
            ST_IDLE: begin
                if (grant_x_s) begin
                    state_d = ST_X_RESP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_X_RESP: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        // Count only arbitrations the bridge actually lost; an X_RESP cycle is not a loss.
        if (grant_x_s || !X_Req) begin
            starve_cnt_d = 3'd0;
        end else if (x_elig_s && grant_m_s && (starve_cnt_q != STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + 3'd1;
        end else begin
            starve_cnt_d = starve_cnt_q;
        end

        // A reset in X_RESP abandons the bridge access; the bridge re-requests afterwards.
        if (Reset) begin
            state_d        = ST_IDLE;
            starve_cnt_d   = 3'd0;
            m_rd_pending_d = 1'b0;
        end else begin
            state_d        = state_d;
        end
    end

    // State registers; synchronous reset is folded into the _d logic above.
    always_ff @(posedge Clk) begin
        state_q        <= state_d;
        starve_cnt_q   <= starve_cnt_d;
        m_rd_pending_q <= m_rd_pending_d;
        m_rd_q         <= m_rd_d;
        x_rd_q         <= x_rd_d;
    end

    assign M_Stall = M_Req && !grant_m_s && !Reset;
    assign M_RD    = m_rd_s;
    assign X_Ack   = x_ack_s;
    assign X_RD    = x_rd_s;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb_dm_port_arbiter
// Drives directed scenarios and random traffic into dm_port_arbiter, with a
// behavioural memory behind the Mem_* port and a reference model of the
// arbitration rules plus a shadow copy of memory contents.

module tb_dm_port_arbiter;

    localparam int LIMIT = 4;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        M_Req, M_WE;
    logic [31:0] M_Addr, M_WD;
    logic [3:0]  M_BE;
    logic        M_Stall;
    logic [31:0] M_RD;
    logic        X_Req, X_WE;
    logic [31:0] X_Addr, X_WD;
    logic [3:0]  X_BE;
    logic        X_Ack;
    logic [31:0] X_RD;
    logic        Mem_En, Mem_WE;
    logic [11:0] Mem_Addr;
    logic [31:0] Mem_WD;
    logic [3:0]  Mem_BE;
    logic [31:0] Mem_RD = 32'd0;

    dm_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .Clk(Clk), .Reset(Reset),
        .M_Req(M_Req), .M_WE(M_WE), .M_Addr(M_Addr), .M_WD(M_WD), .M_BE(M_BE),
        .M_Stall(M_Stall), .M_RD(M_RD),
        .X_Req(X_Req), .X_WE(X_WE), .X_Addr(X_Addr), .X_WD(X_WD), .X_BE(X_BE),
        .X_Ack(X_Ack), .X_RD(X_RD),
        .Mem_En(Mem_En), .Mem_WE(Mem_WE), .Mem_Addr(Mem_Addr), .Mem_WD(Mem_WD),
        .Mem_BE(Mem_BE), .Mem_RD(Mem_RD)
    );

    always #5 Clk = ~Clk;

    // Synchronous single-port memory, read-before-write, one-cycle read latency.
    logic [31:0] mem [0:4095] = '{default: 32'd0};
    always @(posedge Clk) begin
        if (Mem_En) begin
            Mem_RD <= mem[Mem_Addr];
            for (int b = 0; b < 4; b++) begin
                if (Mem_WE && Mem_BE[b]) mem[Mem_Addr][8*b +: 8] <= Mem_WD[8*b +: 8];
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [31:0] shadow [0:4095] = '{default: 32'd0};
    int          sc;
    bit          x_busy;
    bit          x_is_rd;
    logic [31:0] x_data;
    bit          m_pend;
    logic [31:0] m_pend_data;
    logic [31:0] exp_mrd;

    // Observations of the last evaluated cycle, used by directed checks.
    logic        obs_en, obs_we, obs_stall, obs_ack;
    logic [11:0] obs_addr;

    // Evaluate one cycle: compare DUT outputs against the model, then advance.
    task automatic eval_cycle();
        bit          elig, gx, gm;
        logic [11:0] idx;
        logic        e_we;
        logic [31:0] e_wd;
        logic [3:0]  e_be;
        @(negedge Clk);
        obs_en = Mem_En; obs_we = Mem_WE; obs_stall = M_Stall;
        obs_ack = X_Ack; obs_addr = Mem_Addr;
        if (Reset) begin
            chk("rst_mem_en", {31'd0, Mem_En}, 32'd0);
            chk("rst_stall", {31'd0, M_Stall}, 32'd0);
            chk("rst_x_ack", {31'd0, X_Ack}, 32'd0);
            chk("rst_m_rd", M_RD, 32'd0);
            chk("rst_x_rd", X_RD, 32'd0);
            sc = 0; x_busy = 1'b0; m_pend = 1'b0; exp_mrd = 32'd0;
        end else begin
            if (m_pend) exp_mrd = m_pend_data;
            chk("m_rd", M_RD, exp_mrd);
            chk("x_ack", {31'd0, X_Ack}, {31'd0, x_busy});
            if (x_busy && x_is_rd) chk("x_rd", X_RD, x_data);

            elig = !x_busy && X_Req;
            gx   = elig && (!M_Req || sc >= LIMIT);
            gm   = !gx && M_Req;
            idx  = gx ? X_Addr[13:2] : (gm ? M_Addr[13:2] : 12'd0);
            e_we = gx ? X_WE : (gm ? M_WE : 1'b0);
            e_wd = gx ? X_WD : (gm ? M_WD : 32'd0);
            e_be = gx ? X_BE : (gm ? M_BE : 4'd0);

            chk("mem_en", {31'd0, Mem_En}, {31'd0, gx | gm});
            chk("mem_we", {31'd0, Mem_WE}, {31'd0, e_we});
            chk("mem_addr", {20'd0, Mem_Addr}, {20'd0, idx});
            chk("mem_wd", Mem_WD, e_wd);
            chk("mem_be", {28'd0, Mem_BE}, {28'd0, e_be});
            chk("m_stall", {31'd0, M_Stall}, {31'd0, M_Req & !gm});

            if (gx || !X_Req) sc = 0;
            else if (elig && gm) sc = (sc < 7) ? sc + 1 : 7;
            x_busy = gx;
            if (gx) begin
                x_is_rd = !X_WE;
                x_data  = shadow[idx];
            end
            m_pend      = gm && !M_WE;
            m_pend_data = shadow[idx];
            if ((gx || gm) && e_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (e_be[b]) shadow[idx][8*b +: 8] = e_wd[8*b +: 8];
                end
            end
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic quiet_inputs();
        Reset = 1'b0;
        M_Req = 1'b0; M_WE = 1'b0; M_Addr = 32'd0; M_WD = 32'd0; M_BE = 4'd0;
        X_Req = 1'b0; X_WE = 1'b0; X_Addr = 32'd0; X_WD = 32'd0; X_BE = 4'd0;
    endtask

    task automatic do_reset();
        quiet_inputs();
        Reset = 1'b1;
        eval_cycle();
        Reset = 1'b0;
    endtask

    bit m_hold, x_active;

    initial begin
        quiet_inputs();
        sc = 0; x_busy = 1'b0; x_is_rd = 1'b0; x_data = 32'd0;
        m_pend = 1'b0; m_pend_data = 32'd0; exp_mrd = 32'd0;
        @(posedge Clk);
        #1;

        // Seed a word so the M-only load returns non-zero data.
        do_reset();
        M_Req = 1'b1; M_WE = 1'b1; M_Addr = 32'h0000_0010; M_WD = 32'hA5A5_1234; M_BE = 4'hF;
        eval_cycle();
        // M-only load from 0x10
        M_WE = 1'b0; M_WD = 32'd0;
        eval_cycle();
        chk("ld_en", {31'd0, obs_en}, 32'd1);
        chk("ld_addr", {20'd0, obs_addr}, 32'h004);
        chk("ld_stall", {31'd0, obs_stall}, 32'd0);
        M_Req = 1'b0;
        eval_cycle();
        chk("ld_data", M_RD, 32'hA5A5_1234);

        // Bridge-only store
        do_reset();
        X_Req = 1'b1; X_WE = 1'b1; X_Addr = 32'h20; X_WD = 32'hDEAD_BEEF; X_BE = 4'hF;
        eval_cycle();
        chk("bs_we", {31'd0, obs_we}, 32'd1);
        chk("bs_addr", {20'd0, obs_addr}, 32'h008);
        eval_cycle();
        chk("bs_ack", {31'd0, obs_ack}, 32'd1);
        X_Req = 1'b0;
        eval_cycle();
        chk("bs_nogrant", {31'd0, obs_en}, 32'd0);

        // Starvation: M every cycle, bridge held
        do_reset();
        M_Req = 1'b1; M_Addr = 32'h4; X_Req = 1'b1; X_WE = 1'b0; X_Addr = 32'h20;
        for (int c = 0; c < 6; c++) begin
            M_Addr = 32'(c * 4);
            eval_cycle();
            chk($sformatf("sv_stall%0d", c), {31'd0, obs_stall}, (c == 4) ? 32'd1 : 32'd0);
            chk($sformatf("sv_ack%0d", c), {31'd0, obs_ack}, (c == 5) ? 32'd1 : 32'd0);
        end
        X_Req = 1'b0; M_Req = 1'b0;
        eval_cycle();

        // Back-to-back bridge reads with X_Req held
        do_reset();
        X_Req = 1'b1; X_WE = 1'b0; X_Addr = 32'h20;
        for (int c = 0; c < 4; c++) begin
            if (c == 2) X_Addr = 32'h10;
            eval_cycle();
            chk($sformatf("bb_en%0d", c), {31'd0, obs_en}, ((c % 2) == 0) ? 32'd1 : 32'd0);
            chk($sformatf("bb_ack%0d", c), {31'd0, obs_ack}, ((c % 2) == 1) ? 32'd1 : 32'd0);
        end
        X_Req = 1'b0;
        eval_cycle();

        // Reset while the bridge access is in flight
        do_reset();
        X_Req = 1'b1; X_WE = 1'b0; X_Addr = 32'h20;
        eval_cycle();
        chk("rm_grant", {31'd0, obs_en}, 32'd1);
        Reset = 1'b1;
        eval_cycle();
        chk("rm_noack", {31'd0, obs_ack}, 32'd0);
        Reset = 1'b0;
        eval_cycle();
        chk("rm_idle_regrant", {31'd0, obs_en}, 32'd1);
        eval_cycle();
        chk("rm_ack", {31'd0, obs_ack}, 32'd1);

        // Random traffic on a 16-word window so addresses collide often
        do_reset();
        m_hold = 1'b0; x_active = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            Reset = ($urandom_range(0, 59) == 0);
            if (!m_hold) begin
                M_Req  = ($urandom_range(0, 2) != 0);
                M_WE   = $urandom_range(0, 1) != 0;
                M_Addr = $urandom & 32'hFFFF_C03F;
                M_WD   = $urandom;
                M_BE   = 4'($urandom);
            end
            if (!x_active) begin
                X_Req  = ($urandom_range(0, 2) == 0);
                X_WE   = $urandom_range(0, 1) != 0;
                X_Addr = $urandom & 32'hFFFF_C03F;
                X_WD   = $urandom;
                X_BE   = 4'($urandom);
                x_active = X_Req;
            end
            eval_cycle();
            m_hold = obs_stall;
            if (obs_ack) x_active = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
